spi_mem_master: RTL and testbench
=================================

Name: spi_mem_master

Overview:
- SPI mode-0 initiator for an external 25-series SPI EEPROM/flash; the counterpart of the emulator's SPI responder.
- Presents the same begin_rd/begin_wr/finish memory handshake used by the other memory clients.
- The serial protocol or a dump engine can read and program a real part, for capture into SRAM or for bench-driving the emulator.
- Bit-bangs spi_clk from mclk.

Parameters:
- CLK_DIV, 4: mclk cycles per spi_clk half-period; must be ≥2.
- ADDR_BYTES, 3: address bytes sent on the wire, 2 or 3.
- CS_HIGH, 8: minimum mclk cycles spi_cs is held high between transactions.

Ports:
- mclk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- begin_rd  in  1  one-cycle request: read one byte at addr.
- begin_wr  in  1  one-cycle request: write data_wr at addr.
- addr  in  20  byte address; latched at the request.
- data_wr  in  8  write data; latched at the request.
- data_rd  out  8  read result; valid from the finish pulse until the next finish.
- finish  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after an accepted request until ready again.
- spi_clk  out  1  SPI clock; idles low.
- spi_mosi  out  1  master out; idles low.
- spi_miso  in  1  master in.
- spi_cs  out  1  active-low chip select; idles high.

Behaviour:
- Reset (asynchronous, active-high): spi_cs=1, spi_clk=0, spi_mosi=0, finish=0, busy=0, data_rd=8'h00, FSM=IDLE. Reset mid-transaction aborts immediately and produces no finish.
- Accept: a request is accepted on an mclk edge where busy=0 and begin_rd or begin_wr is high; that edge is cycle 0.
  - If both are high, the write wins and the read is dropped.
  - Requests while busy=1 are ignored.
  - addr and data_wr are latched at cycle 0.
- Wire address: 24 bits {4'h0, addr} when ADDR_BYTES=3; addr[15:0] when ADDR_BYTES=2. MSB first.
- Frame (shared by all phases), with B = number of bits in the frame:
  - spi_cs falls at cycle 1.
  - CS_SETUP lasts CLK_DIV cycles with spi_clk low.
  - Each bit is a low half of CLK_DIV cycles followed by a high half of CLK_DIV cycles. spi_mosi is updated at the start of the low half. spi_miso is sampled on the last mclk edge of the high half, i.e. the same edge on which spi_clk returns low.
  - CS_HOLD lasts CLK_DIV cycles with spi_clk low.
  - spi_cs rises at cycle 1 + 2·CLK_DIV + 2·B·CLK_DIV, measured from frame start.
  - CS_GAP: spi_cs stays high for CS_HIGH cycles before the next frame or before returning to IDLE.
- Read sequence: one frame: 8'h03, address, 8 dummy bits (mosi=0), B = 8·(2+ADDR_BYTES).
  - data_rd is loaded and finish pulses on the cycle spi_cs rises.
  - Defaults: cycle 329.
  - busy falls after CS_GAP.
- Write sequence:
  1. WREN frame: 8'h06, B=8.
  2. CS_GAP.
  3. WRITE frame: 8'h02, address, data byte.
  4. CS_GAP.
  5. Poll frames: 8'h05 plus 8 read bits, B=16. Repeat while the received bit0 (WIP) is 1, with CS_GAP between frames.
  - finish pulses on the spi_cs rise of the first poll frame that returns WIP=0. data_rd is unchanged by writes.
  - Polling is unbounded; the client must use reset to abort.
- FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_GAP. A phase register selects WREN, WRITE, POLL or READ and determines the next frame.
- Counters:
  - Divider counter 0..CLK_DIV-1.
  - Bit counter 0..B-1.
  - Gap counter 0..CS_HIGH-1.
  - Counters do not wrap mid-frame; the bit counter clears at each frame start.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- spi_clk never toggles while spi_cs=1.

Test Plan:
- Read with defaults, addr=20'h12345, slave model returns 8'hA5:
  - mosi carries 03 01 23 45 00.
  - finish at cycle 329; data_rd=8'hA5.
  - spi_clk shows exactly 40 rising edges.
  - busy drops 8 cycles later.
- Write with addr=20'h00010, data_wr=8'h5A, slave WIP=1 for two polls then 0:
  - mosi shows frames 06 | 02 00 00 10 5A | 05 ×3.
  - spi_cs is high ≥8 cycles between each frame.
  - exactly one finish, after the third poll.
- ADDR_BYTES=2, read addr=20'hFABCD: mosi carries 03 AB CD 00; finish at cycle 1+8+256=265.
- begin_rd and begin_wr asserted together: write sequence only. A begin_rd during busy: ignored, no extra frame, no extra finish.
- Reset asserted mid-SHIFT: same cycle spi_cs=1, spi_clk=0, busy=0, no finish. A new read after reset completes normally.
- CLK_DIV=2, back-to-back reads at ff and 00 (addr 20'hFFFFF then 20'h00000): each high and low half of spi_clk is 2 cycles; the second frame starts ≥CS_HIGH cycles after the first spi_cs rise.

Source files
------------

// File: rtl/spi_mem_master.sv
// SPI mode-0 initiator for 25-series EEPROM/flash parts behind the begin_rd/begin_wr/finish handshake.
// Reads are a single 03h frame; writes run WREN, WRITE, then poll RDSR until WIP clears.
module spi_mem_master #(
  parameter int CLK_DIV    = 4,
  parameter int ADDR_BYTES = 3,
  parameter int CS_HIGH    = 8
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        begin_rd,
  input  logic        begin_wr,
  input  logic [19:0] addr,
  input  logic [7:0]  data_wr,
  output logic [7:0]  data_rd,
  output logic        finish,
  output logic        busy,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs
);

  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW      = $clog2(CS_HIGH + 1);
  localparam int FRAME_W = 40;

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_GAP} state_t;
  typedef enum logic [1:0] {PH_WREN, PH_WRITE, PH_POLL, PH_READ} phase_t;

  state_t               state;
  phase_t               phase;
  logic [DW-1:0]        div;
  logic [5:0]           bit_cnt;
  logic [GW-1:0]        gap;
  logic                 last_frame;
  logic [19:0]          addr_q;
  logic [7:0]           wdata_q;
  logic [FRAME_W-1:0]   tx;
  logic [7:0]           rx;

  // Frame contents are left-aligned; bits past the frame length are never shifted out.
  function automatic logic [FRAME_W-1:0] frame_bits(input phase_t ph, input logic [19:0] a,
                                                    input logic [7:0] d);
    logic [31:0] body;
    logic [7:0]  payload;
    payload = (ph == PH_WRITE) ? d : 8'h00;
    if (ADDR_BYTES == 3) body = {4'h0, a, payload};
    else                 body = {a[15:0], payload, 8'h00};
    case (ph)
      PH_WREN:  frame_bits = {8'h06, 32'h0};
      PH_POLL:  frame_bits = {8'h05, 32'h0};
      PH_WRITE: frame_bits = {8'h02, body};
      default:  frame_bits = {8'h03, body};
    endcase
  endfunction

  function automatic logic [5:0] frame_len(input phase_t ph);
    case (ph)
      PH_WREN: frame_len = 6'd8;
      PH_POLL: frame_len = 6'd16;
      default: frame_len = 6'(8 * (2 + ADDR_BYTES));
    endcase
  endfunction

  logic div_last, gap_last, bit_last, accept, frame_start, setup_end, sample, shift_next;

  always_comb begin
    div_last    = (div == DW'(CLK_DIV - 1));
    gap_last    = (gap == GW'(CS_HIGH - 1));
    bit_last    = (bit_cnt == frame_len(phase) - 6'd1);
    accept      = (state == IDLE) && (begin_rd || begin_wr);
    frame_start = (state == CS_GAP) && gap_last && !last_frame;
    setup_end   = (state == CS_SETUP) && div_last;
    sample      = (state == SHIFT) && div_last && spi_clk;
    shift_next  = sample && !bit_last;
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= PH_READ;
      div        <= '0;
      bit_cnt    <= '0;
      gap        <= '0;
      last_frame <= 1'b0;
      spi_cs     <= 1'b1;
      spi_clk    <= 1'b0;
      spi_mosi   <= 1'b0;
      finish     <= 1'b0;
      busy       <= 1'b0;
      data_rd    <= 8'h00;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          // Pre-load the gap counter so the first frame opens on the next edge.
          if (accept) begin
            phase      <= begin_wr ? PH_WREN : PH_READ;
            busy       <= 1'b1;
            last_frame <= 1'b0;
            gap        <= GW'(CS_HIGH - 1);
            state      <= CS_GAP;
          end
        end
        CS_GAP: begin
          if (gap_last) begin
            if (last_frame) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              spi_cs  <= 1'b0;
              div     <= '0;
              bit_cnt <= '0;
              state   <= CS_SETUP;
            end
          end else begin
            gap <= gap + 1'b1;
          end
        end
        CS_SETUP: begin
          if (div_last) begin
            div      <= '0;
            spi_mosi <= tx[FRAME_W-1];
            state    <= SHIFT;
          end else begin
            div <= div + 1'b1;
          end
        end
        SHIFT: begin
          if (div_last) begin
            div     <= '0;
            spi_clk <= !spi_clk;
            if (spi_clk) begin
              if (bit_last) begin
                spi_mosi <= 1'b0;
                state    <= CS_HOLD;
              end else begin
                bit_cnt  <= bit_cnt + 6'd1;
                spi_mosi <= tx[FRAME_W-1];
              end
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        CS_HOLD: begin
          if (div_last) begin
            div    <= '0;
            spi_cs <= 1'b1;
            gap    <= '0;
            state  <= CS_GAP;
            case (phase)
              PH_READ: begin
                data_rd    <= rx;
                finish     <= 1'b1;
                last_frame <= 1'b1;
              end
              PH_WREN:  phase <= PH_WRITE;
              PH_WRITE: phase <= PH_POLL;
              default: begin
                if (!rx[0]) begin
                  finish     <= 1'b1;
                  last_frame <= 1'b1;
                end
              end
            endcase
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift datapath: request latches and shift registers, steered by the strobes above.
  always_ff @(posedge mclk) begin
    if (accept) begin
      addr_q  <= addr;
      wdata_q <= data_wr;
    end
    if (frame_start)
      tx <= frame_bits(phase, addr_q, wdata_q);
    else if (setup_end || shift_next)
      tx <= {tx[FRAME_W-2:0], 1'b0};
    if (sample)
      rx <= {rx[6:0], spi_miso};
  end

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: three parameterisations share one 25-series responder model,
// with a scoreboard of expected finish cycle and read data per request.
module tb_spi_mem_master;
  localparam int CS_HIGH = 8;

  logic        mclk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  begin_rd = '0;
  logic [2:0]  begin_wr = '0;
  logic [19:0] addr = '0;
  logic [7:0]  data_wr = '0;
  logic [7:0]  data_rd [3];
  logic [2:0]  finish, busy, spi_clk, spi_mosi, spi_cs;
  logic        spi_miso = 1'b0;

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  spi_mem_master #(.CLK_DIV(4), .ADDR_BYTES(3), .CS_HIGH(CS_HIGH)) dut0 (
    .mclk(mclk), .reset(reset), .begin_rd(begin_rd[0]), .begin_wr(begin_wr[0]),
    .addr(addr), .data_wr(data_wr), .data_rd(data_rd[0]), .finish(finish[0]),
    .busy(busy[0]), .spi_clk(spi_clk[0]), .spi_mosi(spi_mosi[0]),
    .spi_miso(spi_miso), .spi_cs(spi_cs[0]));
  spi_mem_master #(.CLK_DIV(4), .ADDR_BYTES(2), .CS_HIGH(CS_HIGH)) dut1 (
    .mclk(mclk), .reset(reset), .begin_rd(begin_rd[1]), .begin_wr(begin_wr[1]),
    .addr(addr), .data_wr(data_wr), .data_rd(data_rd[1]), .finish(finish[1]),
    .busy(busy[1]), .spi_clk(spi_clk[1]), .spi_mosi(spi_mosi[1]),
    .spi_miso(spi_miso), .spi_cs(spi_cs[1]));
  spi_mem_master #(.CLK_DIV(2), .ADDR_BYTES(3), .CS_HIGH(CS_HIGH)) dut2 (
    .mclk(mclk), .reset(reset), .begin_rd(begin_rd[2]), .begin_wr(begin_wr[2]),
    .addr(addr), .data_wr(data_wr), .data_rd(data_rd[2]), .finish(finish[2]),
    .busy(busy[2]), .spi_clk(spi_clk[2]), .spi_mosi(spi_mosi[2]),
    .spi_miso(spi_miso), .spi_cs(spi_cs[2]));

  function automatic int cd_of(input int k);
    return (k == 2) ? 2 : 4;
  endfunction
  function automatic int ab_of(input int k);
    return (k == 1) ? 2 : 3;
  endfunction

  // Responder model on the bus of the selected instance
  logic [1:0]  sel = 2'd0;
  logic [7:0]  resp = 8'h00;
  int          poll_limit = 0;
  wire         s_clk  = spi_clk[sel];
  wire         s_cs   = spi_cs[sel];
  wire         s_mosi = spi_mosi[sel];
  logic [7:0]  mlog[$];
  int          frames = 0, polls = 0, last_edges = 0, stray = 0, nbit = 0, edges = 0;
  logic [7:0]  sh = 8'h00, cmd = 8'h00;
  logic        p_clk = 1'b0, p_cs = 1'b1;

  function automatic logic slave_bit(input int n);
    int off;
    logic [7:0] stat;
    off  = 8 + 8 * ab_of(int'(sel));
    stat = (polls < poll_limit) ? 8'hA3 : 8'hA2;
    if (cmd == 8'h03 && n >= off && n < off + 8) return resp[7 - (n - off)];
    if (cmd == 8'h05 && n >= 8 && n < 16) return stat[7 - (n - 8)];
    return 1'b0;
  endfunction

  always @(s_clk or s_cs) begin
    if (s_cs !== p_cs) begin
      if (!s_cs) begin
        nbit = 0; edges = 0; spi_miso = 1'b0;
      end else begin
        frames++; last_edges = edges;
        if (cmd == 8'h05) polls++;
      end
    end
    if (s_clk !== p_clk) begin
      if (s_clk) begin
        if (s_cs) stray++;
        else begin
          sh = {sh[6:0], s_mosi}; nbit++; edges++;
          if (nbit % 8 == 0) begin
            mlog.push_back(sh);
            if (nbit == 8) cmd = sh;
          end
        end
      end else if (!s_cs) begin
        spi_miso = slave_bit(nbit);
      end
    end
    p_cs = s_cs; p_clk = s_clk;
  end

  typedef struct { int inst; bit rd; bit wr; logic [19:0] addr; logic [7:0] wdata;
                   logic [7:0] resp; int wip; int poke; } vec_t;
  typedef struct { int cyc; logic [7:0] data; } sb_t;

  vec_t       vecs[7];
  sb_t        sbq[$];
  logic [7:0] last_rd [3];
  int n_checks = 0, n_fail = 0;
  int acc = 0, fin_cyc = 0, busy_fall = 0, mon_sel = -1, last_rise = 0, last_chg = 0;
  bit have_rise = 0, first_rise = 0;
  logic prev_busy = 1'b0, m_cs = 1'b1, m_clk = 1'b0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One mclk cycle, sampled on the falling edge, with the protocol monitor folded in.
  task automatic tick();
    sb_t e;
    int d;
    @(negedge mclk);
    for (int j = 0; j < 3; j++) begin
      if (finish[j] === 1'b1) begin
        if (j != int'(sel) || sbq.size() == 0) check(1'b0, "unexpected_finish", j, -1);
        else begin
          e = sbq.pop_front();
          check(cyc - acc == e.cyc, "finish_cycle", cyc - acc, e.cyc);
          check(data_rd[j] == e.data, "data_rd", int'(data_rd[j]), int'(e.data));
          fin_cyc = cyc;
        end
      end
    end
    if (mon_sel != int'(sel)) begin
      mon_sel = int'(sel); have_rise = 0;
      m_cs = spi_cs[sel]; m_clk = spi_clk[sel]; prev_busy = busy[sel];
    end
    if (prev_busy && !busy[sel]) busy_fall = cyc;
    prev_busy = busy[sel];
    if (!reset) begin
      d = cd_of(int'(sel));
      if (m_cs && !spi_cs[sel]) begin
        if (have_rise) check(cyc - last_rise >= CS_HIGH, "cs_gap_min", cyc - last_rise, CS_HIGH);
        first_rise = 1;
      end
      if (!m_cs && spi_cs[sel]) begin
        have_rise = 1; last_rise = cyc;
      end
      if (spi_clk[sel] != m_clk) begin
        if (spi_clk[sel]) begin
          if (!first_rise) check(cyc - last_chg == d, "clk_low_half", cyc - last_chg, d);
          first_rise = 0;
        end else begin
          check(cyc - last_chg == d, "clk_high_half", cyc - last_chg, d);
        end
        last_chg = cyc;
      end
    end
    m_cs = spi_cs[sel]; m_clk = spi_clk[sel];
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] eb[$];
    int nb[$];
    int d, ab, t, rise, base, fbase, n;
    sb_t e;
    sel = v.inst[1:0]; resp = v.resp; poll_limit = polls + v.wip;
    d = cd_of(v.inst); ab = ab_of(v.inst);
    if (v.wr) begin
      eb.push_back(8'h06); nb.push_back(1);
      eb.push_back(8'h02);
      if (ab == 3) eb.push_back({4'h0, v.addr[19:16]});
      eb.push_back(v.addr[15:8]); eb.push_back(v.addr[7:0]); eb.push_back(v.wdata);
      nb.push_back(2 + ab);
      for (int k = 0; k <= v.wip; k++) begin
        eb.push_back(8'h05); eb.push_back(8'h00); nb.push_back(2);
      end
    end else begin
      eb.push_back(8'h03);
      if (ab == 3) eb.push_back({4'h0, v.addr[19:16]});
      eb.push_back(v.addr[15:8]); eb.push_back(v.addr[7:0]); eb.push_back(8'h00);
      nb.push_back(2 + ab);
    end
    t = 1; rise = 0;
    foreach (nb[k]) begin
      rise = t + 2 * d + 16 * nb[k] * d;
      t = rise + CS_HIGH;
    end
    e.cyc = rise;
    e.data = v.wr ? last_rd[v.inst] : v.resp;
    last_rd[v.inst] = e.data;
    sbq.push_back(e);
    base = mlog.size(); fbase = frames;
    addr = v.addr; data_wr = v.wdata;
    begin_rd[v.inst] = v.rd; begin_wr[v.inst] = v.wr;
    acc = cyc + 1;
    tick();
    begin_rd = '0; begin_wr = '0;
    for (n = 0; n < 20000; n++) begin
      if (v.poke > 0 && n == v.poke) begin
        addr = 20'h0F0F0; begin_rd[v.inst] = 1'b1;
      end
      tick();
      begin_rd = '0;
      if (!busy[sel]) break;
    end
    check(n < 20000, "busy_timeout", n, 20000);
    check(sbq.size() == 0, "finish_seen", sbq.size(), 0);
    sbq.delete();
    check(frames - fbase == nb.size(), "frame_count", frames - fbase, nb.size());
    check(mlog.size() - base == eb.size(), "mosi_byte_count", mlog.size() - base, eb.size());
    foreach (eb[k])
      if (base + k < mlog.size()) check(mlog[base + k] == eb[k], "mosi_byte", int'(mlog[base + k]), int'(eb[k]));
    check(last_edges == 8 * nb[nb.size() - 1], "clk_rise_count", last_edges, 8 * nb[nb.size() - 1]);
    check(busy_fall - fin_cyc == CS_HIGH, "busy_drop", busy_fall - fin_cyc, CS_HIGH);
    check(stray == 0, "clk_while_cs_high", stray, 0);
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{0, 1'b1, 1'b0, 20'h12345, 8'h00, 8'hA5, 0, 0};
    vecs[1] = '{0, 1'b0, 1'b1, 20'h00010, 8'h5A, 8'h00, 2, 0};
    vecs[2] = '{1, 1'b1, 1'b0, 20'hFABCD, 8'h00, 8'h3C, 0, 0};
    vecs[3] = '{0, 1'b1, 1'b1, 20'h00020, 8'h77, 8'hEE, 0, 0};
    vecs[4] = '{2, 1'b1, 1'b0, 20'hFFFFF, 8'h00, 8'h81, 0, 0};
    vecs[5] = '{2, 1'b1, 1'b0, 20'h00000, 8'h00, 8'h7E, 0, 0};
    vecs[6] = '{0, 1'b1, 1'b0, 20'h00ABC, 8'h00, 8'h5C, 0, 60};
    for (int j = 0; j < 3; j++) last_rd[j] = 8'h00;

    repeat (2) tick();
    for (int j = 0; j < 3; j++) begin
      check(spi_cs[j] == 1'b1, "reset_cs", spi_cs[j], 1);
      check(spi_clk[j] == 1'b0, "reset_clk", spi_clk[j], 0);
      check(spi_mosi[j] == 1'b0, "reset_mosi", spi_mosi[j], 0);
      check(finish[j] == 1'b0, "reset_finish", finish[j], 0);
      check(busy[j] == 1'b0, "reset_busy", busy[j], 0);
      check(data_rd[j] == 8'h00, "reset_data_rd", int'(data_rd[j]), 0);
    end
    reset = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Abort a read mid-shift, then confirm a fresh read still works.
    sel = 2'd0; resp = 8'h11; addr = 20'h54321;
    begin_rd[0] = 1'b1;
    tick();
    begin_rd = '0;
    repeat (100) tick();
    check(busy[0] == 1'b1 && spi_cs[0] == 1'b0, "pre_reset_active", {busy[0], spi_cs[0]}, 2);
    reset = 1'b1;
    #1;
    check(spi_cs[0] == 1'b1, "abort_cs", spi_cs[0], 1);
    check(spi_clk[0] == 1'b0, "abort_clk", spi_clk[0], 0);
    check(busy[0] == 1'b0, "abort_busy", busy[0], 0);
    check(finish[0] == 1'b0, "abort_finish", finish[0], 0);
    check(data_rd[0] == 8'h00, "abort_data_rd", int'(data_rd[0]), 0);
    repeat (3) tick();
    reset = 1'b0;
    for (int j = 0; j < 3; j++) last_rd[j] = 8'h00;
    repeat (20) tick();
    rv = '{0, 1'b1, 1'b0, 20'h0C0DE, 8'h00, 8'h96, 0, 0};
    run_vec(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
